bootram_bus_bridge: RTL and testbench
=====================================

BOOTRAM_BUS_BRIDGE -- requirements
Module: bootram_bus_bridge

Interface
REQ-001 Parameter: ADDR_W, default 11, byte-address width of the boot RAM (2K x 8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset.
REQ-004 mem_valid  input  1  picorv32 native-bus request.
REQ-005 mem_addr  input  32  byte address; bits [ADDR_W-1:2] used, others ignored (decode is upstream).
REQ-006 mem_wdata  input  32  write data, little-endian.
REQ-007 mem_wstrb  input  4  byte enables; 4'b0000 = read.
REQ-008 mem_ready  output  1  one-cycle completion pulse.
REQ-009 mem_rdata  output  32  assembled read word.
REQ-010 ram_ce  output  1  RAM clock enable.
REQ-011 ram_oce  output  1  RAM output-register enable; constant 1.
REQ-012 ram_reset  output  1  RAM reset; equals ~resetn.
REQ-013 ram_wre  output  1  RAM write enable.
REQ-014 ram_ad  output  ADDR_W  RAM byte address.
REQ-015 ram_din  output  8  RAM write byte.
REQ-016 ram_dout  input  8  RAM read byte; valid the cycle after its address is presented with ram_ce=1.

Function
REQ-017 FSM states: IDLE, RD (4 cycles), RLAST, WR (4 cycles), DONE; 2-bit byte counter k.
REQ-018 IDLE: mem_valid=1 and mem_wstrb=0 -> RD, k=0; mem_valid=1 and mem_wstrb!=0 -> WR, k=0; else stay.
REQ-019 RD cycle k: ram_ad={mem_addr[ADDR_W-1:2],k}, ram_ce=1, ram_wre=0; k=3 -> RLAST.
REQ-020 Capture: ram_dout sampled at end of each cycle following an RD issue into mem_rdata[8j+7:8j] for byte j (captures in RD k=1..3 and RLAST).
REQ-021 RLAST: ram_ce=0, capture byte 3, -> DONE.
REQ-022 WR cycle k: ram_ad as REQ-019, ram_din=mem_wdata[8k+7:8k], ram_wre=mem_wstrb[k], ram_ce=1; k=3 -> DONE.
REQ-023 DONE: mem_ready=1 for exactly one cycle, -> IDLE; mem_valid in DONE is not accepted.
REQ-024 Latency from mem_valid sampled in IDLE (cycle 0): read mem_ready in cycle 6, write in cycle 5; next request accepted in cycle 7 / 6.
REQ-025 mem_rdata stable from DONE until next read's first capture; writes leave it unchanged.
REQ-026 mem_addr/mem_wdata/mem_wstrb are held by the master during a transaction; bridge does not register them.
REQ-027 mem_valid deassertion mid-transaction is ignored; transaction completes.
REQ-028 Outside RD/WR: ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0.

Reset
REQ-029 resetn=0 at any edge: state=IDLE, k=0, mem_ready=0, mem_rdata=0, ram_wre=0, ram_ce=0 from next cycle; in-flight transaction abandoned with no mem_ready.
REQ-030 ram_reset=1 while resetn=0.

Configuration
REQ-031 Macro BOOTRAM_WRITE_EN: defined -> WR path per REQ-022.
REQ-032 Not defined -> write request goes IDLE->DONE (mem_ready in cycle 1), ram_wre constant 0, RAM unmodified.

Verification
REQ-033 RAM model bytes 0..3 = 6F,13,13,13; read addr 0x0 -> mem_ready in cycle 6, mem_rdata=0x1313136F.
REQ-034 Write addr 0x10 wdata 0xA5B6C7D8 wstrb 4'b0101 (macro on), then read 0x10 over bytes 00,00,00,00 -> 0x00B600D8... corrected: strobes 0,2 write D8,B6 -> read 0x00B600D8.
REQ-035 Same write with macro off -> mem_ready in cycle 1, ram_wre never 1, read returns 0x00000000.
REQ-036 Back-to-back reads 0x7FC then 0x000 with mem_valid held high -> two mem_ready pulses 7 cycles apart, byte addresses 7FC..7FF then 000..003.
REQ-037 resetn=0 during RD k=2 -> no mem_ready, mem_rdata=0, ram_ce=0 next cycle; new read after reset completes normally.
REQ-038 mem_valid dropped in WR k=1 -> all four byte cycles still issued, mem_ready in cycle 5.

Source files
------------

// File: rtl/bootram_bus_bridge.sv
// Bridges the picorv32 32-bit native bus onto a 2Kx8 registered-output boot RAM, one byte per cycle.
// Latency: read mem_ready 6 cycles after acceptance, write 5 (1 when BOOTRAM_WRITE_EN is undefined).
// Backpressure: mem_ready is held off until the sequence finishes; requests seen in DONE are ignored.
module bootram_bus_bridge #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_reset,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RLAST,
        S_WR,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] rdata_q, rdata_d;

    logic [ADDR_W-3:0] word_addr;
    assign word_addr = mem_addr[ADDR_W-1:2];

`ifdef BOOTRAM_WRITE_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W], mem_addr[1:0], mem_wdata};
`endif

    assign ram_oce   = 1'b1;
    assign ram_reset = ~resetn;
    assign mem_rdata = rdata_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        rdata_d   = rdata_q;
        mem_ready = 1'b0;
        ram_ce    = 1'b0;
        ram_wre   = 1'b0;
        ram_ad    = '0;
        ram_din   = '0;

        case (state_q)
            S_IDLE: begin
                k_d = 2'd0;
                if (mem_valid) begin
                    if (mem_wstrb == 4'b0000) begin
                        state_d = S_RD;
                    end else begin
`ifdef BOOTRAM_WRITE_EN
                        state_d = S_WR;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_RD: begin
                ram_ce = 1'b1;
                ram_ad = {word_addr, k_q};
                // RAM output lags the address by one cycle, so this cycle lands the previous byte
                if (k_q != 2'd0) begin
                    rdata_d[{k_q - 2'd1, 3'b000} +: 8] = ram_dout;
                end
                if (k_q == 2'd3) begin
                    state_d = S_RLAST;
                    k_d     = 2'd0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_RLAST: begin
                rdata_d[31:24] = ram_dout;
                state_d        = S_DONE;
            end
`ifdef BOOTRAM_WRITE_EN
            S_WR: begin
                ram_ce  = 1'b1;
                ram_ad  = {word_addr, k_q};
                ram_din = mem_wdata[{k_q, 3'b000} +: 8];
                ram_wre = mem_wstrb[k_q];
                if (k_q == 2'd3) begin
                    state_d = S_DONE;
                    k_d     = 2'd0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
`endif
            S_DONE: begin
                mem_ready = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                k_d     = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_bootram_bus_bridge.sv
// Directed bench for bootram_bus_bridge: vector table of bus transactions plus hand-written corner sequences.
module tb_bootram_bus_bridge;

`ifdef BOOTRAM_WRITE_EN
    localparam bit WE = 1'b1;
`else
    localparam bit WE = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ram_ce;
    logic        ram_oce;
    logic        ram_reset;
    logic        ram_wre;
    logic [10:0] ram_ad;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    bootram_bus_bridge #(.ADDR_W(11)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_reset (ram_reset),
        .ram_wre   (ram_wre),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Boot RAM model: byte read data appears the cycle after the address is presented
    logic [7:0] mem [0:2047];
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[0] = 8'h6F; mem[1] = 8'h13; mem[2] = 8'h13; mem[3] = 8'h13;
        mem[11'h7FC] = 8'h11; mem[11'h7FD] = 8'h22; mem[11'h7FE] = 8'h33; mem[11'h7FF] = 8'h44;
        ram_dout = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) mem[ram_ad] <= ram_din;
            ram_dout <= mem[ram_ad];
        end
    end

    // Bus observer: RAM address trace, write-enable pulses, idle-output rule violations
    logic [10:0] trace [$];
    int          wre_cnt = 0;
    int          viol    = 0;
    always @(negedge clk) begin
        if (ram_ce) trace.push_back(ram_ad);
        if (ram_wre) wre_cnt++;
        if (!ram_ce && (ram_ad != 11'd0 || ram_din != 8'd0 || ram_wre)) viol++;
        if (!WE && ram_wre) viol++;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one transaction; lat = cycle of mem_ready counted from acceptance, 0 on timeout
    task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int drop_at, output int lat);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == drop_at) mem_valid = 1'b0;
            if (mem_ready) begin
                lat = n;
                break;
            end
        end
        mem_valid = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int          lat;
        int          base;
        int          wre0;
        int          t0;
        int          ready_seen;
        logic [31:0] last_rd;

        vecs[0] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h1313136F,                   6};
        vecs[1] = '{1'b1, 32'h0000_0010, 32'hA5B6C7D8,  4'b0101, 32'h1313136F,                   WE ? 5 : 1};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, WE ? 32'h00B600D8 : 32'h0,      6};
        vecs[3] = '{1'b0, 32'h0000_07FC, 32'h0,         4'b0000, 32'h44332211,                   6};
        vecs[4] = '{1'b0, 32'hFFFF_F800, 32'h0,         4'b0000, 32'h1313136F,                   6};
        vecs[5] = '{1'b1, 32'h0000_0020, 32'hCAFEF00D,  4'b1111, 32'h1313136F,                   WE ? 5 : 1};
        vecs[6] = '{1'b0, 32'h0000_0020, 32'h0,         4'b0000, WE ? 32'hCAFEF00D : 32'h0,      6};
        vecs[7] = '{1'b1, 32'h0000_0024, 32'h99887766,  4'b1000, WE ? 32'hCAFEF00D : 32'h0,      WE ? 5 : 1};
        vecs[8] = '{1'b0, 32'h0000_0026, 32'h0,         4'b0000, WE ? 32'h99000000 : 32'h0,      6};

        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        repeat (3) @(negedge clk);
        chk("reset_ram_reset", {31'd0, ram_reset}, 32'd1);
        chk("reset_ready",     {31'd0, mem_ready}, 32'd0);
        chk("reset_rdata",     mem_rdata,          32'd0);
        chk("reset_ce",        {31'd0, ram_ce},    32'd0);
        chk("oce_const",       {31'd0, ram_oce},   32'd1);
        resetn = 1'b1;
        @(negedge clk);
        chk("run_ram_reset",   {31'd0, ram_reset}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            base = trace.size();
            wre0 = wre_cnt;
            do_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wr ? vecs[i].wstrb : 4'b0000, 0, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_wre_pulses", i), wre_cnt - wre0, WE ? $countones(vecs[i].wstrb) : 0);
                chk($sformatf("v%0d_ram_cycles", i), trace.size() - base, WE ? 4 : 0);
            end else begin
                chk($sformatf("v%0d_ram_cycles", i), trace.size() - base, 4);
                if (trace.size() - base == 4)
                    chk($sformatf("v%0d_first_ad", i), {21'd0, trace[base]}, {21'd0, vecs[i].addr[10:2], 2'b00});
            end
        end

        // Back-to-back reads with mem_valid held through DONE
        base = trace.size();
        do_txn(32'h0000_07FC, 32'h0, 4'b0000, 0, lat);
        chk("b2b_first_lat",   lat,       6);
        chk("b2b_first_rdata", mem_rdata, 32'h44332211);
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0000;
        t0 = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (mem_ready) begin
                t0 = n;
                break;
            end
        end
        mem_valid = 1'b0;
        chk("b2b_gap",          t0,                  7);
        chk("b2b_second_rdata", mem_rdata,           32'h1313136F);
        chk("b2b_ram_cycles",   trace.size() - base, 8);
        if (trace.size() - base == 8) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("b2b_ad_hi%0d", j), {21'd0, trace[base + j]},     32'h7FC + j);
                chk($sformatf("b2b_ad_lo%0d", j), {21'd0, trace[base + 4 + j]}, j);
            end
        end

        // Reset asserted while the read sits in RD with k=2
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_07FC;
        mem_wstrb = 4'b0000;
        ready_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_ready) ready_seen++;
        end
        chk("rst_mid_pre_ce", {31'd0, ram_ce}, 32'd1);
        chk("rst_mid_pre_ad", {21'd0, ram_ad}, 32'h7FE);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_ce",    {31'd0, ram_ce},    32'd0);
        chk("rst_mid_rdata", mem_rdata,          32'd0);
        chk("rst_mid_ramrst",{31'd0, ram_reset}, 32'd1);
        if (mem_ready) ready_seen++;
        resetn = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (mem_ready) ready_seen++;
        end
        chk("rst_mid_no_ready", ready_seen, 0);
        do_txn(32'h0000_0000, 32'h0, 4'b0000, 0, lat);
        chk("rst_after_lat",   lat,       6);
        chk("rst_after_rdata", mem_rdata, 32'h1313136F);

        // mem_valid dropped during WR k=1: the write must still finish
        base = trace.size();
        wre0 = wre_cnt;
        last_rd = mem_rdata;
        do_txn(32'h0000_0030, 32'h01020304, 4'b1111, 2, lat);
        chk("drop_lat",        lat,                 WE ? 5 : 1);
        chk("drop_ram_cycles", trace.size() - base, WE ? 4 : 0);
        chk("drop_wre_pulses", wre_cnt - wre0,      WE ? 4 : 0);
        chk("drop_rdata_hold", mem_rdata,           last_rd);
        do_txn(32'h0000_0030, 32'h0, 4'b0000, 0, lat);
        chk("drop_readback",   mem_rdata,           WE ? 32'h01020304 : 32'h0);

        repeat (2) @(negedge clk);
        chk("idle_outputs_rule", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
